// File: rtl/pdm_capture_sequencer.sv
// rtl/pdm_capture_sequencer.sv - PDM capture sequencer: warm-up discard, framed sample capture, FIFO drain.
// Optional feature macro: PDM_SEQ_AUTO_REARM_EN (frame end reloads the counter and keeps capturing).
module pdm_capture_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int WARMUP_SAMPLES = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic [COUNT_WIDTH-1:0]          num_samples,
  output logic                            mic_en,
  input  logic [DATA_WIDTH-1:0]           pcm_in,
  input  logic                            pcm_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CAPTURE, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] num_q;
  logic [COUNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [COUNT_WIDTH-1:0] warm_cnt_q, warm_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;

  // Each entry holds {last, sample}.
  logic [DATA_WIDTH:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q;
  logic [DATA_WIDTH:0]    head;
  logic                   fifo_full, push, pop, sample_last;

  assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
  assign m_valid     = (level_q != '0);
  assign pop         = m_valid && m_ready;
  assign head        = mem[rd_ptr_q];
  assign m_data      = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last      = m_valid ? head[DATA_WIDTH] : 1'b0;
  assign mic_en      = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;
  // A zero frame length means continuous capture, so no sample is ever tagged last.
  assign sample_last = (num_q != '0) && (sample_cnt_q == num_q - COUNT_WIDTH'(1));

  // Next-state, counter and push decisions for the capture sequence.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    warm_cnt_d   = warm_cnt_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;
    push         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sample_cnt_d = '0;
          warm_cnt_d   = '0;
          overflow_d   = 1'b0;
          state_d      = (WARMUP_SAMPLES == 0) ? S_CAPTURE : S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (pcm_ready) begin
          if (warm_cnt_q == COUNT_WIDTH'(WARMUP_SAMPLES - 1)) state_d = S_CAPTURE;
          else warm_cnt_d = warm_cnt_q + COUNT_WIDTH'(1);
        end
      end
      S_CAPTURE: begin
        if (pcm_ready) begin
          // A dropped sample still advances the count so frame length stays aligned to the mic.
          sample_cnt_d = sample_cnt_q + COUNT_WIDTH'(1);
          if (fifo_full) overflow_d = 1'b1;
          else push = 1'b1;
          if (sample_last) begin
`ifdef PDM_SEQ_AUTO_REARM_EN
            sample_cnt_d = '0;
            done_d       = 1'b1;
`else
            state_d      = S_DRAIN;
`endif
          end
        end
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((level_q == '0) || ((level_q == LW'(1)) && pop)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      sample_cnt_q <= '0;
      warm_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      if ((state_q == S_IDLE) && start) num_q <= num_samples;
    end
  end

  // FIFO pointers and occupancy; full is judged before any same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // FIFO storage; outputs are masked while empty so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {sample_last, pcm_in};
  end

endmodule

// File: tb/tb_pdm_capture_sequencer.sv
// tb/tb_pdm_capture_sequencer.sv - scoreboard bench for pdm_capture_sequencer.
module tb_pdm_capture_sequencer;

  localparam int DW = 16;
  localparam int FD = 4;
  localparam int CW = 16;
  localparam int WS = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          mic_en;
  logic [DW-1:0] pcm_in = '0;
  logic          pcm_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad = 0;
  logic [DW:0] sb[$];
  logic [DW:0] mon_exp;

  pdm_capture_sequencer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW), .WARMUP_SAMPLES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .num_samples(num_samples),
    .mic_en(mic_en), .pcm_in(pcm_in), .pcm_ready(pcm_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got data=%0h last=%0b required none", m_data, m_last);
      end else begin
        mon_exp = sb.pop_front();
        if ({m_last, m_data} !== mon_exp) begin
          bad++;
          $display("FAIL pop_data: got data=%0h last=%0b required data=%0h last=%0b",
                   m_data, m_last, mon_exp[DW-1:0], mon_exp[DW]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] val, input bit exp_push, input bit exp_last);
    if (exp_push) sb.push_back({exp_last, val});
    pcm_in = val;
    pcm_ready = 1'b1;
    cyc(1);
    pcm_ready = 1'b0;
  endtask

  task automatic begin_frame(input logic [CW-1:0] ns);
    num_samples = ns;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic warmup();
    for (int i = 0; i < WS; i++) begin
      strobe(DW'(16'h0F00 + i), 1'b0, 1'b0);
      cyc(1);
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc(1);
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    cyc(1);
    chk({name, "_done_low"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    cyc(2);
    chk("rst_mic_en", 32'(mic_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);
    rst_n = 1'b1;
    cyc(1);

`ifndef PDM_SEQ_AUTO_REARM_EN
    // Frame of 3 after 4 warm-up strobes: values 5,6,7 emerge, 7 tagged last.
    m_ready = 1'b1;
    begin_frame(16'd3);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_mic_en", 32'(mic_en), 1);
    for (int v = 1; v <= 7; v++) begin
      strobe(DW'(v), v >= 5, v == 7);
      if (v < 7) cyc(1);
    end
    chk("t1_mic_off", 32'(mic_en), 0);
    chk("t1_drain_busy", 32'(busy), 1);
    wait_done("t1", 10);

    // Overflow: depth 4, frame of 6, consumer stalled.
    m_ready = 1'b0;
    begin_frame(16'd6);
    warmup();
    for (int v = 1; v <= 6; v++) begin
      strobe(DW'(16'h0200 + v), v <= 4, 1'b0);
      cyc(1);
    end
    chk("t2_level", 32'(fifo_level), 4);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_mic_off", 32'(mic_en), 0);
    m_ready = 1'b1;
    wait_done("t2", 12);
    chk("t2_overflow_held", 32'(overflow), 1);
`endif

    // Continuous capture of 10, then stop; no sample is tagged last.
    m_ready = 1'b1;
    begin_frame(16'd0);
    chk("t3_overflow_cleared", 32'(overflow), 0);
    warmup();
    for (int v = 0; v < 10; v++) begin
      strobe(DW'(16'h0300 + v), 1'b1, 1'b0);
      cyc(1);
    end
    do_stop();
    wait_done("t3", 10);

    // Stop during warm-up: immediate return with done, nothing queued.
    begin_frame(16'd5);
    strobe(16'h0401, 1'b0, 1'b0);
    cyc(1);
    strobe(16'h0402, 1'b0, 1'b0);
    do_stop();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 1);
    chk("t4_m_valid", 32'(m_valid), 0);
    cyc(1);
    chk("t4_done_low", 32'(done), 0);
    chk("t4_level", 32'(fifo_level), 0);

    // Reset mid-capture with three entries queued.
    m_ready = 1'b0;
    begin_frame(16'd0);
    warmup();
    for (int v = 0; v < 3; v++) begin
      strobe(DW'(16'h0500 + v), 1'b0, 1'b0);
      cyc(1);
    end
    chk("t5_level_before", 32'(fifo_level), 3);
    rst_n = 1'b0;
    #1;
    chk("t5_m_valid", 32'(m_valid), 0);
    chk("t5_mic_en", 32'(mic_en), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_level", 32'(fifo_level), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    m_ready = 1'b1;
    begin_frame(16'd2);
    warmup();
    strobe(16'h05A1, 1'b1, 1'b0);
    cyc(1);
    strobe(16'h05A2, 1'b1, 1'b1);
`ifdef PDM_SEQ_AUTO_REARM_EN
    cyc(2);
    do_stop();
`endif
    wait_done("t5", 10);

`ifdef PDM_SEQ_AUTO_REARM_EN
    // Auto re-arm: frames of 2, last on every second sample, done after each.
    begin_frame(16'd2);
    warmup();
    for (int v = 1; v <= 6; v++) begin
      strobe(DW'(16'h0600 + v), 1'b1, (v % 2) == 0);
      chk($sformatf("t6_done_s%0d", v), 32'(done), 32'((v % 2) == 0));
      chk($sformatf("t6_mic_en_s%0d", v), 32'(mic_en), 1);
      cyc(1);
    end
    do_stop();
    wait_done("t6", 10);
`endif

    cyc(2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
